// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the NoC switch allocator slice.
//   NPORT     : number of input ports competing for the output
//   SELW      : width of the flit mux select
//   SEL_IDLE  : select value driven when no flit is transferred
//   state_t   : allocator state encoding (IDLE / LOCK)
//   next_port : round-robin successor of a port index, wrapping after NPORT-1
// ---------------------------------------------------------------------------
package noc_pkg;

  localparam int NPORT = 6;
  localparam int SELW  = 3;
  localparam logic [SELW-1:0] SEL_IDLE = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // Successor of port p in round-robin order; the last port wraps to 0.
  function automatic logic [SELW-1:0] next_port(input logic [SELW-1:0] p);
    logic [SELW-1:0] r;
    if (p >= SELW'(NPORT - 1)) begin
      r = '0;
    end else begin
      r = p + SELW'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/sw_alloc_6x1_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter_6
// Combinational round-robin pick over NPORT requesters.
//   req   [NPORT-1:0] : per-port request
//   ptr   [SELW-1:0]  : highest-priority port (0..NPORT-1)
//   valid             : at least one request present
//   idx   [SELW-1:0]  : first requesting port found from ptr upward, mod NPORT
// ---------------------------------------------------------------------------
module rr_arbiter_6
  import noc_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  logic [SELW-1:0]  ptr,
  output logic             valid,
  output logic [SELW-1:0]  idx
);

  logic [SELW:0] w_cand;

  // Walk the ports in priority order starting at ptr. The candidate index is
  // computed one bit wider so ptr+k can exceed NPORT-1 before being folded
  // back; the first requester hit is latched by the valid flag.
  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    w_cand = '0;
    for (int k = 0; k < NPORT; k++) begin
      w_cand = {1'b0, ptr} + (SELW + 1)'(k);
      if (w_cand >= (SELW + 1)'(NPORT)) begin
        w_cand = w_cand - (SELW + 1)'(NPORT);
      end
      if (!valid && req[w_cand[SELW-1:0]]) begin
        valid = 1'b1;
        idx   = w_cand[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/sw_alloc_6x1.sv
// ---------------------------------------------------------------------------
// sw_alloc_6x1
// Six-input, one-output switch allocator with packet locking and credit-based
// flow control toward a downstream buffer of CREDITS slots.
//   clk        : clock, all state on rising edge
//   rst        : synchronous active-high reset
//   req   [5:0]: port i holds a head-of-queue flit
//   tail  [5:0]: port i's head flit is a tail (meaningful only with req[i])
//   credit_in  : one-cycle pulse, downstream freed one slot
//   gnt   [5:0]: one-hot pop pulse to the winning port
//   sel   [2:0]: flit mux select, SEL_IDLE when nothing moves
//   en         : flit mux enable, high on transfer cycles
//   busy       : a packet currently holds the output
//   credit_cnt : available downstream credits
//   credit_err : sticky, credit returned while already at CREDITS
// ---------------------------------------------------------------------------
module sw_alloc_6x1
  import noc_pkg::*;
#(
  parameter int CREDITS = 4,
  parameter int CW      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NPORT-1:0] req,
  input  logic [NPORT-1:0] tail,
  input  logic             credit_in,
  output logic [NPORT-1:0] gnt,
  output logic [SELW-1:0]  sel,
  output logic             en,
  output logic             busy,
  output logic [CW-1:0]    credit_cnt,
  output logic             credit_err
);

  state_t          r_state;
  logic [SELW-1:0] r_owner;
  logic [SELW-1:0] r_rr_ptr;
  logic [CW-1:0]   r_credit;
  logic            r_credit_err;

  state_t          w_state_nxt;
  logic [SELW-1:0] w_owner_nxt;
  logic [SELW-1:0] w_rr_ptr_nxt;
  logic            w_xfer;
  logic [SELW-1:0] w_idx;
  logic            w_arb_valid;
  logic [SELW-1:0] w_arb_idx;
  logic            w_has_credit;

  rr_arbiter_6 u_arb (
    .req   (req),
    .ptr   (r_rr_ptr),
    .valid (w_arb_valid),
    .idx   (w_arb_idx)
  );

  assign w_has_credit = (r_credit != '0);

  // Next-state and grant decode. Grants are combinational so a flit can pop
  // in the same cycle its request appears. While rst is high everything is
  // forced idle so a reset mid-packet never pops the old owner again.
  // In LOCK only the owner is looked at; other requesters simply wait.
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    w_xfer       = 1'b0;
    w_idx        = '0;
    gnt          = '0;
    sel          = SEL_IDLE;
    en           = 1'b0;

    if (!rst) begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_arb_valid && w_has_credit) begin
            w_xfer = 1'b1;
            w_idx  = w_arb_idx;
            if (tail[w_arb_idx]) begin
              w_rr_ptr_nxt = next_port(w_arb_idx);
            end else begin
              w_owner_nxt = w_arb_idx;
              w_state_nxt = ST_LOCK;
            end
          end
        end
        ST_LOCK: begin
          if (req[r_owner] && w_has_credit) begin
            w_xfer = 1'b1;
            w_idx  = r_owner;
            if (tail[r_owner]) begin
              w_rr_ptr_nxt = next_port(r_owner);
              w_state_nxt  = ST_IDLE;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase

      if (w_xfer) begin
        en         = 1'b1;
        sel        = w_idx;
        gnt[w_idx] = 1'b1;
      end
    end
  end

  // State, owner and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Credit counter. A transfer and a returned credit in the same cycle cancel.
  // A credit returned while already full would overflow the buffer model, so
  // the count saturates and the sticky error flag records the protocol slip.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit     <= CW'(CREDITS);
      r_credit_err <= 1'b0;
    end else begin
      if (w_xfer && !credit_in) begin
        r_credit <= r_credit - CW'(1);
      end else if (credit_in && !w_xfer) begin
        if (r_credit == CW'(CREDITS)) begin
          r_credit_err <= 1'b1;
        end else begin
          r_credit <= r_credit + CW'(1);
        end
      end
    end
  end

  assign busy       = (r_state == ST_LOCK) && !rst;
  assign credit_cnt = r_credit;
  assign credit_err = r_credit_err;

endmodule

// File: tb/tb_sw_alloc_6x1.sv
// ---------------------------------------------------------------------------
// tb_sw_alloc_6x1
// Directed self-checking bench for sw_alloc_6x1 (CREDITS=4, CW=3).
// Inputs change 1 time unit after the rising edge; combinational outputs and
// registered state are both checked before the next edge.
// ---------------------------------------------------------------------------
module tb_sw_alloc_6x1;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] req;
  logic [5:0] tail;
  logic       credit_in;
  logic [5:0] gnt;
  logic [2:0] sel;
  logic       en;
  logic       busy;
  logic [2:0] credit_cnt;
  logic       credit_err;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  sw_alloc_6x1 #(
    .CREDITS (4),
    .CW      (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .tail       (tail),
    .credit_in  (credit_in),
    .gnt        (gnt),
    .sel        (sel),
    .en         (en),
    .busy       (busy),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs and let the combinational outputs settle.
  task automatic applyStimulus(input logic rstV, input logic [5:0] reqV,
                               input logic [5:0] tailV, input logic cinV);
    rst       = rstV;
    req       = reqV;
    tail      = tailV;
    credit_in = cinV;
    #2;
  endtask

  // Check the full output set for the current cycle.
  task automatic checkCycle(input string tag, input logic [5:0] eGnt,
                            input logic [2:0] eSel, input logic eEn,
                            input logic eBusy, input logic [2:0] eCnt,
                            input logic eErr);
    checkOutput({tag, ".gnt"},  32'(gnt),        32'(eGnt));
    checkOutput({tag, ".sel"},  32'(sel),        32'(eSel));
    checkOutput({tag, ".en"},   32'(en),         32'(eEn));
    checkOutput({tag, ".busy"}, 32'(busy),       32'(eBusy));
    checkOutput({tag, ".cnt"},  32'(credit_cnt), 32'(eCnt));
    checkOutput({tag, ".err"},  32'(credit_err), 32'(eErr));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 6'b000000, 6'b000000, 1'b0);
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    tail      = '0;
    credit_in = 1'b0;
    tick();

    // Reset: outputs forced idle even with every port requesting.
    applyStimulus(1'b1, 6'b111111, 6'b111111, 1'b0);
    checkCycle("rst_force", 6'b000000, 3'd7, 1'b0, 1'b0, 3'd4, 1'b0);
    tick();

    // Single-flit packet from port 0, zero-cycle grant, credit 4->3.
    applyStimulus(1'b0, 6'b000001, 6'b000001, 1'b0);
    checkCycle("s1_grant", 6'b000001, 3'd0, 1'b1, 1'b0, 3'd4, 1'b0);
    tick();
    // rr_ptr is now 1: port 1 beats port 0.
    applyStimulus(1'b0, 6'b000011, 6'b000011, 1'b0);
    checkCycle("s1_ptr1", 6'b000010, 3'd1, 1'b1, 1'b0, 3'd3, 1'b0);
    tick();
    applyStimulus(1'b0, 6'b000000, 6'b000000, 1'b0);
    checkCycle("s1_after", 6'b000000, 3'd7, 1'b0, 1'b0, 3'd2, 1'b0);

    // Ports 2 and 5 alternate, credit returned every cycle.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 6'b100100, 6'b111111, 1'b1);
      if (i % 2 == 0) checkCycle($sformatf("s2_alt%0d", i), 6'b000100, 3'd2, 1'b1, 1'b0, 3'd4, 1'b0);
      else            checkCycle($sformatf("s2_alt%0d", i), 6'b100000, 3'd5, 1'b1, 1'b0, 3'd4, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 6'b000000, 6'b000000, 1'b0);
    checkCycle("s2_end", 6'b000000, 3'd7, 1'b0, 1'b0, 3'd4, 1'b0);

    // Port 2 single flit moves rr_ptr to 3, then port 3 sends 3 flits
    // while port 0 waits; afterwards the search wraps to port 0.
    doReset();
    applyStimulus(1'b0, 6'b000100, 6'b000100, 1'b1);
    checkCycle("s3_pre", 6'b000100, 3'd2, 1'b1, 1'b0, 3'd4, 1'b0);
    tick();
    applyStimulus(1'b0, 6'b001001, 6'b000001, 1'b1);
    checkCycle("s3_f1", 6'b001000, 3'd3, 1'b1, 1'b0, 3'd4, 1'b0);
    tick();
    applyStimulus(1'b0, 6'b001001, 6'b000001, 1'b1);
    checkCycle("s3_f2", 6'b001000, 3'd3, 1'b1, 1'b1, 3'd4, 1'b0);
    tick();
    applyStimulus(1'b0, 6'b001001, 6'b001001, 1'b1);
    checkCycle("s3_f3", 6'b001000, 3'd3, 1'b1, 1'b1, 3'd4, 1'b0);
    tick();
    applyStimulus(1'b0, 6'b000001, 6'b000001, 1'b1);
    checkCycle("s3_wrap", 6'b000001, 3'd0, 1'b1, 1'b0, 3'd4, 1'b0);
    tick();

    // Credit exhaustion: four transfers, then holding until a credit returns.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 6'b000010, 6'b000010, 1'b0);
      checkCycle($sformatf("s4_x%0d", i), 6'b000010, 3'd1, 1'b1, 1'b0, 3'(4 - i), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 6'b000010, 6'b000010, 1'b0);
    checkCycle("s4_hold", 6'b000000, 3'd7, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 6'b000010, 6'b000010, 1'b1);
    checkCycle("s4_cin", 6'b000000, 3'd7, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 6'b000010, 6'b000010, 1'b0);
    checkCycle("s4_resume", 6'b000010, 3'd1, 1'b1, 1'b0, 3'd1, 1'b0);
    tick();
    applyStimulus(1'b0, 6'b000000, 6'b000000, 1'b0);
    checkCycle("s4_end", 6'b000000, 3'd7, 1'b0, 1'b0, 3'd0, 1'b0);

    // Credit overflow: saturate at 4 and set the sticky error.
    doReset();
    applyStimulus(1'b0, 6'b000000, 6'b000000, 1'b1);
    checkCycle("s5_cin", 6'b000000, 3'd7, 1'b0, 1'b0, 3'd4, 1'b0);
    tick();
    applyStimulus(1'b0, 6'b000000, 6'b000000, 1'b0);
    checkCycle("s5_err", 6'b000000, 3'd7, 1'b0, 1'b0, 3'd4, 1'b1);
    tick();
    applyStimulus(1'b0, 6'b000001, 6'b000001, 1'b0);
    checkCycle("s5_xfer", 6'b000001, 3'd0, 1'b1, 1'b0, 3'd4, 1'b1);
    tick();
    applyStimulus(1'b0, 6'b000000, 6'b000000, 1'b0);
    checkCycle("s5_sticky", 6'b000000, 3'd7, 1'b0, 1'b0, 3'd3, 1'b1);
    doReset();
    applyStimulus(1'b0, 6'b000000, 6'b000000, 1'b0);
    checkCycle("s5_clear", 6'b000000, 3'd7, 1'b0, 1'b0, 3'd4, 1'b0);

    // Reset mid-packet: port 4 locks, stalls, then reset abandons it.
    applyStimulus(1'b0, 6'b010000, 6'b000000, 1'b0);
    checkCycle("s6_head", 6'b010000, 3'd4, 1'b1, 1'b0, 3'd4, 1'b0);
    tick();
    applyStimulus(1'b0, 6'b000000, 6'b000000, 1'b0);
    checkCycle("s6_stall", 6'b000000, 3'd7, 1'b0, 1'b1, 3'd3, 1'b0);
    tick();
    applyStimulus(1'b1, 6'b010000, 6'b000000, 1'b0);
    checkCycle("s6_inrst", 6'b000000, 3'd7, 1'b0, 1'b0, 3'd3, 1'b0);
    tick();
    applyStimulus(1'b0, 6'b010001, 6'b000001, 1'b0);
    checkCycle("s6_after", 6'b000001, 3'd0, 1'b1, 1'b0, 3'd4, 1'b0);
    tick();
    applyStimulus(1'b0, 6'b010000, 6'b010000, 1'b0);
    checkCycle("s6_newhead", 6'b010000, 3'd4, 1'b1, 1'b0, 3'd3, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
